spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master datapath. It accepts a one-word transfer request and generates SCLK and chip select at a programmable rate. It issues the load, shift and sample strobes that drive the PISO transmit register and the SIPO receive register, and it reports busy and completion to the host logic. It sits between the host-side command interface and the shift registers, and owns all SPI bus timing.

---
 rtl/spi_xfer_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master transfer sequencer. Generates CS_n and a
// registered SCLK at a programmable rate, and decodes the load/shift/sample
// strobes for the PISO transmit and SIPO receive registers from the
// registered state, divider and edge counters.
module spi_xfer_ctrl #(
    parameter int WordLen  = 8,
    parameter int DivWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic                CPOL,
    input  logic                CPHA,
    input  logic [DivWidth-1:0] ClkDiv,
    output logic                Busy,
    output logic                Done,
    output logic                CS_n,
    output logic                SCLK,
    output logic                LoadPISO,
    output logic                ShiftEdge,
    output logic                SampleEdge,
    output logic                EnSIPO
);

    localparam int EdgeW = $clog2(2 * WordLen + 1);
    localparam logic [EdgeW-1:0] FirstEdge = EdgeW'(1);
    localparam logic [EdgeW-1:0] LastEdge  = EdgeW'(2 * WordLen);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [DivWidth-1:0] clkdiv_q, clkdiv_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [EdgeW-1:0]    edge_q, edge_d;
    logic                sclk_q, sclk_d;

    logic div_wrap;
    logic edge_evt;
    logic sample_now;
    logic shift_skip;

    // Half-period boundary of the divider; an edge event in XFER.
    assign div_wrap   = (div_q == clkdiv_q);
    assign edge_evt   = (state_q == S_XFER) && div_wrap;
    // Odd edges are leading: CPHA=0 samples on them, CPHA=1 on the even ones.
    assign sample_now = cpha_q ? ~edge_q[0] : edge_q[0];
    // The one non-sample edge per word that must not advance the PISO.
    assign shift_skip = cpha_q ? (edge_q == FirstEdge) : (edge_q == LastEdge);

    // State, shadow settings, counters and SCLK register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            clkdiv_q <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state_q  <= state_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            clkdiv_q <= clkdiv_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
        end
    end

    // Next-state, counter and SCLK sequencing.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d  = state_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        clkdiv_d = clkdiv_q;
        div_d    = div_q;
        edge_d   = edge_q;
        sclk_d   = cpol_q;

        case (state_q)
            S_IDLE: begin
                sclk_d = CPOL;
                div_d  = '0;
                if (Start) begin
                    cpol_d   = CPOL;
                    cpha_d   = CPHA;
                    clkdiv_d = ClkDiv;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    edge_d  = FirstEdge;
                    state_d = S_XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_XFER: begin
                sclk_d = sclk_q;
                if (div_wrap) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (edge_q == LastEdge) begin
                        state_d = S_HOLD;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_DONE);
    assign CS_n       = !((state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_HOLD));
    assign SCLK       = sclk_q;
    assign LoadPISO   = (state_q == S_SETUP) && (div_q == '0);
    assign EnSIPO     = (state_q == S_XFER);
    assign SampleEdge = edge_evt && sample_now;
    assign ShiftEdge  = edge_evt && !sample_now && !shift_skip;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: table-driven bench for spi_xfer_ctrl with a bus monitor,
// a mode-aware SPI slave and a SIPO capture register.
module tb_spi_xfer_ctrl;

    localparam int WordLen  = 8;
    localparam int DivWidth = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                Start;
    logic                CPOL;
    logic                CPHA;
    logic [DivWidth-1:0] ClkDiv;
    logic                Busy, Done, CS_n, SCLK, LoadPISO, ShiftEdge, SampleEdge, EnSIPO;

    spi_xfer_ctrl #(.WordLen(WordLen), .DivWidth(DivWidth)) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .ClkDiv     (ClkDiv),
        .Busy       (Busy),
        .Done       (Done),
        .CS_n       (CS_n),
        .SCLK       (SCLK),
        .LoadPISO   (LoadPISO),
        .ShiftEdge  (ShiftEdge),
        .SampleEdge (SampleEdge),
        .EnSIPO     (EnSIPO)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cumulative bus statistics, sampled on the falling clock edge.
    typedef struct {
        int busy;
        int cs_low;
        int load;
        int shift;
        int samp;
        int samp_low;
        int done;
        int rise;
        int fall;
        int overlap;
        int done_bad;
        int gap_one;
    } mon_t;

    mon_t mon = '{default: 0};
    logic prev_sclk = 1'b0;
    logic prev_done = 1'b0;
    int   idle_run  = 0;

    always @(negedge clk) begin
        mon.busy     <= mon.busy + int'(Busy);
        mon.cs_low   <= mon.cs_low + int'(!CS_n);
        mon.load     <= mon.load + int'(LoadPISO);
        mon.shift    <= mon.shift + int'(ShiftEdge);
        mon.samp     <= mon.samp + int'(SampleEdge);
        mon.samp_low <= mon.samp_low + int'(SampleEdge && !SCLK);
        mon.done     <= mon.done + int'(Done);
        mon.overlap  <= mon.overlap + int'(SampleEdge && ShiftEdge);
        mon.done_bad <= mon.done_bad + int'(Done && !Busy) + int'(prev_done && Busy);
        if (!CS_n) begin
            mon.rise <= mon.rise + int'(SCLK && !prev_sclk);
            mon.fall <= mon.fall + int'(!SCLK && prev_sclk);
        end
        if (!Busy) begin
            idle_run <= idle_run + 1;
        end else begin
            if (idle_run == 1) mon.gap_one <= mon.gap_one + 1;
            idle_run <= 0;
        end
        prev_sclk <= SCLK;
        prev_done <= Done;
    end

    // SPI slave: shifts s_data out MSB-first in the mode set by s_cpol/s_cpha.
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       miso   = 1'b0;
    int         s_cnt  = 0;
    logic       s_cs_prev = 1'b1;
    logic       s_sclk_prev = 1'b0;

    always @(CS_n or SCLK) begin
        if (s_cs_prev && !CS_n) begin
            s_cnt = 0;
            if (!s_cpha) begin
                miso  = s_data[7];
                s_cnt = 1;
            end
        end else if (!CS_n && (SCLK != s_sclk_prev)) begin
            if ((s_cpha ? (SCLK != s_cpol) : (SCLK == s_cpol)) && s_cnt < 8) begin
                miso  = s_data[7 - s_cnt];
                s_cnt = s_cnt + 1;
            end
        end
        s_cs_prev   = CS_n;
        s_sclk_prev = SCLK;
    end

    // SIPO receive register, MSB first.
    logic [7:0] rx = 8'h00;
    always @(posedge clk) begin
        if (SampleEdge) rx <= {rx[6:0], miso};
    end

    // Single-word transfer: Start high across exactly one posedge, then wait
    // (bounded) for Busy to drop and the bus to settle.
    task automatic do_xfer(input string tag);
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check({tag, "_busy_first"}, Busy, 1);
        check({tag, "_cs_first"}, CS_n, 0);
        check({tag, "_load_first"}, LoadPISO, 1);
        for (int i = 0; i < 200 && Busy; i++) @(negedge clk);
        if (Busy) check({tag, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] div;
        logic       cpol;
        logic       cpha;
        logic [7:0] data;
        int         busy;
        int         cs_low;
        int         samp_low;
    } vec_t;

    vec_t vecs[4];
    mon_t s0;

    initial begin
        vecs[0] = '{8'd0, 1'b0, 1'b0, 8'hA5, 19, 18, 8};
        vecs[1] = '{8'd3, 1'b1, 1'b1, 8'hA5, 73, 72, 8};
        vecs[2] = '{8'd1, 1'b0, 1'b1, 8'h3C, 37, 36, 0};
        vecs[3] = '{8'd2, 1'b1, 1'b0, 8'h96, 55, 54, 0};

        rst    = 1'b1;
        Start  = 1'b0;
        CPOL   = 1'b1;
        CPHA   = 1'b0;
        ClkDiv = '0;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_cs_n", CS_n, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_strobes", {LoadPISO, ShiftEdge, SampleEdge, EnSIPO}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_sclk_tracks_cpol", SCLK, 1);

        // Table-driven single transfers.
        for (int v = 0; v < 4; v++) begin
            CPOL   = vecs[v].cpol;
            CPHA   = vecs[v].cpha;
            ClkDiv = vecs[v].div;
            s_cpol = vecs[v].cpol;
            s_cpha = vecs[v].cpha;
            s_data = vecs[v].data;
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("v%0d_idle_sclk", v), SCLK, vecs[v].cpol);
            s0 = mon;
            do_xfer($sformatf("v%0d", v));
            check($sformatf("v%0d_busy_cycles", v), mon.busy - s0.busy, vecs[v].busy);
            check($sformatf("v%0d_cs_low", v), mon.cs_low - s0.cs_low, vecs[v].cs_low);
            check($sformatf("v%0d_sample_cnt", v), mon.samp - s0.samp, WordLen);
            check($sformatf("v%0d_shift_cnt", v), mon.shift - s0.shift, WordLen - 1);
            check($sformatf("v%0d_load_cnt", v), mon.load - s0.load, 1);
            check($sformatf("v%0d_done_cnt", v), mon.done - s0.done, 1);
            check($sformatf("v%0d_sclk_rise", v), mon.rise - s0.rise, WordLen);
            check($sformatf("v%0d_sclk_fall", v), mon.fall - s0.fall, WordLen);
            check($sformatf("v%0d_sample_at_low", v), mon.samp_low - s0.samp_low, vecs[v].samp_low);
            check($sformatf("v%0d_rx", v), rx, vecs[v].data);
            check($sformatf("v%0d_sclk_end", v), SCLK, vecs[v].cpol);
        end
        check("strobe_overlap", mon.overlap, 0);
        check("done_not_last_busy", mon.done_bad, 0);

        // Start held high for 50 cycles: three back-to-back transfers.
        CPOL   = 1'b0;
        CPHA   = 1'b0;
        ClkDiv = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        s0 = mon;
        Start = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        Start = 1'b0;
        for (int i = 0; i < 200 && Busy; i++) @(negedge clk);
        if (Busy) check("b2b_timeout", 1, 0);
        repeat (3) @(negedge clk);
        #1;
        check("b2b_done_cnt", mon.done - s0.done, 3);
        check("b2b_load_cnt", mon.load - s0.load, 3);
        check("b2b_one_cycle_gaps", mon.gap_one - s0.gap_one, 2);
        check("b2b_busy_cycles", mon.busy - s0.busy, 57);

        // Settings changed mid-transfer keep the captured timing/polarity.
        ClkDiv = 8'd3;
        CPOL   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        s0 = mon;
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(negedge clk);
        ClkDiv = 8'd0;
        CPOL   = 1'b1;
        for (int i = 0; i < 200 && Busy; i++) @(negedge clk);
        if (Busy) check("chg_timeout", 1, 0);
        repeat (3) @(negedge clk);
        #1;
        check("chg_busy_cycles", mon.busy - s0.busy, 73);
        check("chg_sclk_rise", mon.rise - s0.rise, 8);
        check("chg_sample_at_low", mon.samp_low - s0.samp_low, 8);
        check("chg_idle_new_cpol", SCLK, 1);
        s0 = mon;
        do_xfer("chg_next");
        check("chg_next_busy_cycles", mon.busy - s0.busy, 19);
        check("chg_next_sample_at_low", mon.samp_low - s0.samp_low, 0);
        check("chg_next_sclk_fall", mon.fall - s0.fall, 8);

        // Asynchronous reset during the edge-5 event cycle.
        CPOL   = 1'b0;
        ClkDiv = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        s0 = mon;
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 40 && (mon.samp - s0.samp) < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("abort_reached_edge5", mon.samp - s0.samp, 3);
        rst = 1'b1;
        #1;
        check("abort_cs_n", CS_n, 1);
        check("abort_busy", Busy, 0);
        check("abort_sclk", SCLK, 0);
        check("abort_done", Done, 0);
        check("abort_strobes", {LoadPISO, ShiftEdge, SampleEdge, EnSIPO}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("abort_no_done", mon.done - s0.done, 0);
        s0 = mon;
        do_xfer("post_abort");
        check("post_abort_busy_cycles", mon.busy - s0.busy, 19);
        check("post_abort_done_cnt", mon.done - s0.done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
